// File: rtl/nitta_board_pkg.sv
// Shared types and constants for the NITTA board wrapper.
// Mode encodings, slow-clock FSM states and period clamp.
package nitta_board_pkg;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam int MIN_DIV = 2;

  typedef enum logic {
    IDLE,
    PERIOD
  } state_t;

endpackage

// File: rtl/nitta_key_debounce.sv
// Key synchronizer and debouncer for an active-low raw key.
// Emits a one-cycle press pulse on each accepted 1->0 transition.
module nitta_key_debounce #(
  parameter int DEBOUNCE = 50
) (
  input  logic clk_5kHz,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_5kHz) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nitta_step_clock.sv
// Programmable slow clock / single-step controller for the NITTA core.
// Run, step, burst and hold modes plus LED page selection.
module nitta_step_clock
  import nitta_board_pkg::*;
#(
  parameter  int DIV_WIDTH = 16,
  parameter  int DEBOUNCE  = 50,
  parameter  int PAGES     = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                 clk_5kHz,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [7:0]           burst_len,
  input  logic                 step_key_n,
  input  logic                 page_key_n,
  output logic                 slow_clk,
  output logic                 tick,
  output logic                 busy,
  output logic [PW-1:0]        page,
  output logic [CNT_WIDTH-1:0] tick_count
);

  state_t               state, nstate;
  logic [DIV_WIDTH-1:0] cnt, ncnt;
  logic [DIV_WIDTH-1:0] per, nper, per_in;
  logic [8:0]           rem, nrem;
  logic                 stepping, nstepping;
  logic                 start;
  logic                 step_press, page_press;

  nitta_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_key (
    .clk_5kHz(clk_5kHz),
    .rst     (rst),
    .raw_n   (step_key_n),
    .level   (),
    .press   (step_press)
  );

  nitta_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_page_key (
    .clk_5kHz(clk_5kHz),
    .rst     (rst),
    .raw_n   (page_key_n),
    .level   (),
    .press   (page_press)
  );

  assign per_in = (div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div;

  always_comb begin
    nstate    = state;
    ncnt      = cnt;
    nper      = per;
    nrem      = rem;
    nstepping = stepping;
    start     = 1'b0;
    if (state == IDLE) begin
      ncnt = '0;
      unique case (1'b1)
        mode == MODE_RUN: begin
          start = 1'b1;
          nrem  = '0;
        end
        mode == MODE_STEP && step_press: begin
          start = 1'b1;
          nrem  = 9'd1;
        end
        mode == MODE_BURST && step_press: begin
          start = 1'b1;
          nrem  = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
        end
        default: ;
      endcase
    end else if (cnt == per - 1'b1) begin
      if (mode == MODE_RUN) begin
        start = 1'b1;
        nrem  = '0;
      end else if ((mode == MODE_STEP || mode == MODE_BURST)
                   && rem > 9'd1) begin
        start = 1'b1;
        nrem  = rem - 9'd1;
      end else begin
        nstate = IDLE;
        ncnt   = '0;
        nrem   = '0;
      end
    end else begin
      ncnt = cnt + 1'b1;
    end
    // Period length and busy flavour are frozen at count 0
    if (start) begin
      nstate    = PERIOD;
      ncnt      = '0;
      nper      = per_in;
      nstepping = (mode != MODE_RUN);
    end
  end

  always_ff @(posedge clk_5kHz) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      per        <= DIV_WIDTH'(MIN_DIV);
      rem        <= '0;
      stepping   <= 1'b0;
      slow_clk   <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      tick_count <= '0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      per        <= nper;
      rem        <= nrem;
      stepping   <= nstepping;
      slow_clk   <= (nstate == PERIOD) && (ncnt < (nper >> 1));
      tick       <= start;
      busy       <= (nstate == PERIOD) && nstepping;
      tick_count <= tick_count + CNT_WIDTH'(start);
    end
  end

  always_ff @(posedge clk_5kHz) begin
    if (rst) begin
      page <= '0;
    end else if (page_press) begin
      page <= (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
    end
  end

endmodule
